// File: rtl/lane_arbiter_2x1.sv
// lane_arbiter_2x1
//
// Round-robin arbiter and flow-control sequencer between two 8-bit lane FIFOs
// and a single destination FIFO, in the clk_4f domain. It pops one lane per
// cycle, alternating on contention, and pushes the returned word two cycles
// later. The destination's almost-full flag blocks new pops. The FIFO
// thresholds are latched while in INIT and broadcast to all FIFOs.
//
// Ports
//   clk_4f           in   1  clock, all state on posedge
//   reset            in   1  synchronous active-high reset
//   init             in   1  request INIT (threshold load), beats data
//   thr_full_in      in   3  almost-full threshold, latched in INIT
//   thr_empty_in     in   3  almost-empty threshold, latched in INIT
//   empty_0/1        in   1  lane FIFO empty flags
//   data_0/1         in   8  lane FIFO read data, valid the cycle after pop
//   almost_full_out  in   1  destination FIFO almost-full
//   pop_0/1          out  1  lane pop strobes (combinational, one-hot or zero)
//   push_out         out  1  destination push strobe (registered)
//   data_out         out  8  destination write data (registered)
//   thr_full/empty   out  3  latched thresholds
//   state            out  2  RESET=0, INIT=1, IDLE=2, ACTIVE=3
//   idle_out         out  1  state is IDLE
module lane_arbiter_2x1 (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic       init,
  input  logic [2:0] thr_full_in,
  input  logic [2:0] thr_empty_in,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic [7:0] data_0,
  input  logic [7:0] data_1,
  input  logic       almost_full_out,
  output logic       pop_0,
  output logic       pop_1,
  output logic       push_out,
  output logic [7:0] data_out,
  output logic [2:0] thr_full,
  output logic [2:0] thr_empty,
  output logic [1:0] state,
  output logic       idle_out
);

  typedef enum logic [1:0] {
    StReset  = 2'd0,
    StInit   = 2'd1,
    StIdle   = 2'd2,
    StActive = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       pipe_vld_q;  // a pop happened last cycle; its data is on data_x now
  logic       pipe_sel_q;  // lane of that pop
  logic       push_q;
  logic [7:0] data_q;
  logic [2:0] thr_full_q, thr_empty_q;

  logic any_ready;
  logic grant;
  logic grant_sel;

  assign any_ready = ~empty_0 | ~empty_1;

  // Next-state logic; init takes priority over pending data.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StReset:  state_d = StInit;
      StInit:   state_d = init ? StInit : StIdle;
      StIdle:   state_d = init ? StInit : (any_ready ? StActive : StIdle);
      StActive: state_d = init ? StInit : (any_ready ? StActive : StIdle);
      default:  state_d = StReset;
    endcase
  end

  // Grant and lane selection. Lane 1 is chosen when contention favours it or
  // when lane 0 has nothing to give.
  always_comb begin
    grant        = (state_q == StActive) & ~almost_full_out & ~init & ~reset & any_ready;
    grant_sel    = (~empty_0 & ~empty_1) ? ~last_grant_q : empty_0;
    pop_0        = grant & ~grant_sel;
    pop_1        = grant & grant_sel;
    last_grant_d = grant ? grant_sel : last_grant_q;
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state_q      <= StReset;
      last_grant_q <= 1'b1;  // lane 0 wins the first contention
      pipe_vld_q   <= 1'b0;
      pipe_sel_q   <= 1'b0;
      push_q       <= 1'b0;
      data_q       <= 8'h00;
      thr_full_q   <= 3'd0;
      thr_empty_q  <= 3'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      pipe_vld_q   <= grant;
      pipe_sel_q   <= grant_sel;
      // The pipeline drains regardless of state so words popped before an
      // INIT request still reach the destination.
      push_q       <= pipe_vld_q;
      if (pipe_vld_q) begin
        data_q <= pipe_sel_q ? data_1 : data_0;
      end
      if (state_q == StInit) begin
        thr_full_q  <= thr_full_in;
        thr_empty_q <= thr_empty_in;
      end
    end
  end

  assign push_out  = push_q;
  assign data_out  = data_q;
  assign thr_full  = thr_full_q;
  assign thr_empty = thr_empty_q;
  assign state     = state_q;
  assign idle_out  = (state_q == StIdle);

endmodule

// File: tb/tb_lane_arbiter_2x1.sv
module tb_lane_arbiter_2x1;

  logic       clk_4f = 1'b0;
  logic       reset;
  logic       init;
  logic [2:0] thr_full_in;
  logic [2:0] thr_empty_in;
  logic       empty_0;
  logic       empty_1;
  logic [7:0] data_0;
  logic [7:0] data_1;
  logic       almost_full_out;
  logic       pop_0;
  logic       pop_1;
  logic       push_out;
  logic [7:0] data_out;
  logic [2:0] thr_full;
  logic [2:0] thr_empty;
  logic [1:0] state;
  logic       idle_out;

  always #5 clk_4f = ~clk_4f;

  lane_arbiter_2x1 dut (
    .clk_4f          (clk_4f),
    .reset           (reset),
    .init            (init),
    .thr_full_in     (thr_full_in),
    .thr_empty_in    (thr_empty_in),
    .empty_0         (empty_0),
    .empty_1         (empty_1),
    .data_0          (data_0),
    .data_1          (data_1),
    .almost_full_out (almost_full_out),
    .pop_0           (pop_0),
    .pop_1           (pop_1),
    .push_out        (push_out),
    .data_out        (data_out),
    .thr_full        (thr_full),
    .thr_empty       (thr_empty),
    .state           (state),
    .idle_out        (idle_out)
  );

  int n_asserts = 0;
  int n_fail    = 0;

  // Reference model state
  logic [1:0] m_state;
  logic       m_last;
  logic       m_v1;
  logic       m_push;
  logic [7:0] m_dout;
  logic [2:0] m_tf;
  logic [2:0] m_te;

  logic [7:0] lane0_q[$];
  logic [7:0] lane1_q[$];
  logic [7:0] sb_q[$];   // words popped, awaiting their push
  logic [7:0] got_q[$];  // words observed on push_out
  int         n_pops = 0;
  logic       last_pop_lane = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_lanes();
    empty_0 = (lane0_q.size() == 0);
    empty_1 = (lane1_q.size() == 0);
  endtask

  // One clock cycle: entered at posedge+1 with inputs set, leaves at the next posedge+1.
  task automatic cycle();
    logic       ne0, ne1, g, sel;
    logic [7:0] w;
    w = 8'h00;
    drive_lanes();
    @(negedge clk_4f);
    ne0 = (lane0_q.size() != 0);
    ne1 = (lane1_q.size() != 0);
    g   = (m_state == 2'd3) && !almost_full_out && !init && !reset && (ne0 || ne1);
    sel = (ne0 && ne1) ? !m_last : !ne0;
    check("state", state, m_state);
    check("idle_out", idle_out, m_state == 2'd2);
    check("pop_0", pop_0, g && !sel);
    check("pop_1", pop_1, g && sel);
    check("push_out", push_out, m_push);
    check("data_out", data_out, m_dout);
    check("thr_full", thr_full, m_tf);
    check("thr_empty", thr_empty, m_te);
    if (push_out === 1'b1) got_q.push_back(data_out);
    if (g) begin
      n_pops++;
      last_pop_lane = sel;
    end
    if (reset) begin
      m_state = 2'd0;
      m_last  = 1'b1;
      m_v1    = 1'b0;
      m_push  = 1'b0;
      m_dout  = 8'h00;
      m_tf    = 3'd0;
      m_te    = 3'd0;
      sb_q.delete();
    end else begin
      m_push = m_v1;
      if (m_v1) m_dout = sb_q.pop_front();
      if (m_state == 2'd1) begin
        m_tf = thr_full_in;
        m_te = thr_empty_in;
      end
      case (m_state)
        2'd0:    m_state = 2'd1;
        2'd1:    m_state = init ? 2'd1 : 2'd2;
        default: m_state = init ? 2'd1 : ((ne0 || ne1) ? 2'd3 : 2'd2);
      endcase
      m_v1 = g;
      if (g) begin
        m_last = sel;
        w = sel ? lane1_q.pop_front() : lane0_q.pop_front();
        sb_q.push_back(w);
      end
    end
    @(posedge clk_4f);
    #1;
    if (g) begin
      if (sel) data_1 = w;
      else     data_0 = w;
    end
    drive_lanes();
  endtask

  logic [7:0] exp_rr[6]  = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2};
  logic [7:0] exp_sl[2]  = '{8'h3C, 8'hC3};
  logic [7:0] exp_bp[10] = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12,
                             8'h22, 8'h13, 8'h23, 8'h14, 8'h24};

  initial begin
    int base;
    logic stalled;
    reset = 1'b1; init = 1'b0; thr_full_in = 3'd0; thr_empty_in = 3'd0;
    almost_full_out = 1'b0; data_0 = 8'h00; data_1 = 8'h00;
    m_state = 2'd0; m_last = 1'b1; m_v1 = 1'b0; m_push = 1'b0;
    m_dout = 8'h00; m_tf = 3'd0; m_te = 3'd0;
    drive_lanes();
    @(posedge clk_4f);
    #1;

    // Reset and init
    repeat (2) cycle();
    reset = 1'b0; init = 1'b1; thr_full_in = 3'd5; thr_empty_in = 3'd1;
    repeat (3) cycle();
    init = 1'b0;
    repeat (2) cycle();
    check("init_thr_full", thr_full, 3'd5);
    check("init_thr_empty", thr_empty, 3'd1);
    check("init_idle", idle_out, 1'b1);

    // Round robin
    got_q.delete();
    lane0_q = '{8'hA0, 8'hA1, 8'hA2};
    lane1_q = '{8'hB0, 8'hB1, 8'hB2};
    repeat (12) cycle();
    check("rr_count", got_q.size(), 6);
    for (int i = 0; i < 6 && i < got_q.size(); i++) check("rr_order", got_q[i], exp_rr[i]);
    check("rr_idle", state, 2'd2);

    // Single lane
    got_q.delete();
    lane1_q = '{8'h3C, 8'hC3};
    repeat (8) cycle();
    check("sl_count", got_q.size(), 2);
    for (int i = 0; i < 2 && i < got_q.size(); i++) check("sl_order", got_q[i], exp_sl[i]);

    // Backpressure
    got_q.delete();
    lane0_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    lane1_q = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24};
    base = n_pops;
    stalled = 1'b0;
    for (int i = 0; i < 24; i++) begin
      cycle();
      if (!stalled && (n_pops - base == 3)) begin
        almost_full_out = 1'b1;
        repeat (4) cycle();
        check("bp_pushes_before_stall", got_q.size(), 3);
        almost_full_out = 1'b0;
        stalled = 1'b1;
      end
    end
    check("bp_stalled", stalled, 1'b1);
    check("bp_count", got_q.size(), 10);
    for (int i = 0; i < 10 && i < got_q.size(); i++) check("bp_order", got_q[i], exp_bp[i]);

    // Reset mid-stream
    lane0_q = '{8'h31, 8'h32, 8'h33};
    lane1_q = '{8'h41, 8'h42, 8'h43};
    base = n_pops;
    for (int i = 0; i < 6 && n_pops == base; i++) cycle();
    check("rst_pre_pop_seen", n_pops > base, 1'b1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("rst_push_cleared", push_out, 1'b0);
    check("rst_data_cleared", data_out, 8'h00);
    base = n_pops;
    for (int i = 0; i < 10 && n_pops == base; i++) cycle();
    check("rst_grant_seen", n_pops > base, 1'b1);
    check("rst_first_lane", last_pop_lane, 1'b0);
    repeat (12) cycle();

    // Init while active
    lane0_q = '{8'h51, 8'h52, 8'h53};
    lane1_q = '{8'h61, 8'h62, 8'h63};
    base = n_pops;
    for (int i = 0; i < 6 && n_pops == base; i++) cycle();
    check("ia_pop_seen", n_pops > base, 1'b1);
    init = 1'b1; thr_full_in = 3'd6; thr_empty_in = 3'd2;
    base = n_pops;
    repeat (3) cycle();
    check("ia_no_pops", n_pops - base, 0);
    init = 1'b0;
    repeat (12) cycle();
    check("ia_thr_full", thr_full, 3'd6);
    check("ia_thr_empty", thr_empty, 3'd2);
    check("ia_drained", lane0_q.size() + lane1_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/lane_arbiter_2x1.md
# lane_arbiter_2x1

Round-robin arbiter and flow-control sequencer for the two 8-bit lane FIFOs behind the 1x2 demux stage. It pops words from lane FIFO 0 and lane FIFO 1 and pushes them into a single destination FIFO, holding off whenever the destination reports almost-full. It also holds the FIFO threshold configuration that is loaded during INIT and broadcasts it to the FIFOs. The block sits in the `clk_4f` domain between the lane FIFOs and the output FIFO.

## Interface
- No parameters. Data width is fixed at 8 and threshold width at 3.
- `clk_4f`  in  1  Single clock. Everything is sampled on `posedge clk_4f`.
- `reset`  in  1  Synchronous, active-high reset.
- `init`  in  1  Requests the INIT state, in which thresholds are loaded.
- `thr_full_in`  in  3  Almost-full threshold. Latched only in INIT.
- `thr_empty_in`  in  3  Almost-empty threshold. Latched only in INIT.
- `empty_0`, `empty_1`  in  1  Empty flags from lane FIFOs 0 and 1.
- `data_0`, `data_1`  in  8  Read data from lane FIFOs 0 and 1. Valid the cycle after the matching pop.
- `almost_full_out`  in  1  Almost-full flag from the destination FIFO.
- `pop_0`, `pop_1`  out  1  Pop strobes to lane FIFOs 0 and 1. Combinational (Mealy). At most one is high in any cycle.
- `push_out`  out  1  Push strobe to the destination FIFO. Registered.
- `data_out`  out  8  Data to the destination FIFO. Registered.
- `thr_full`, `thr_empty`  out  3  Latched thresholds, sent to all FIFOs.
- `state`  out  2  Current state: RESET=0, INIT=1, IDLE=2, ACTIVE=3.
- `idle_out`  out  1  High when `state` is IDLE.

## Operation
- State transitions:
  - `reset`=1 forces RESET at the next edge from any state.
  - RESET goes to INIT on the first edge with `reset`=0.
  - INIT stays in INIT while `init`=1, and goes to IDLE when `init`=0.
  - IDLE goes to INIT if `init`=1. Otherwise it goes to ACTIVE if `empty_0`=0 or `empty_1`=0. Otherwise it stays in IDLE.
  - ACTIVE goes to INIT if `init`=1. Otherwise it goes to IDLE if both empties are 1. Otherwise it stays in ACTIVE.
  - `init` has priority over data.
- Thresholds: in INIT, `thr_full` and `thr_empty` load `thr_full_in` and `thr_empty_in` on every edge. They hold their value in all other states.
- Grant condition: a grant is issued only when all of these hold: `state`=ACTIVE, `almost_full_out`=0, `init`=0, `reset`=0, and at least one empty flag is 0.
- Lane selection:
  - If both lanes are non-empty, grant the lane opposite to `last_grant`.
  - If only one lane is non-empty, grant that lane.
  - The granted lane's `pop_x`=1 in the same cycle, and `last_grant` updates to that lane at the edge.
- Pipeline:
  - A pop in cycle N is registered into `sel_d` and `vld_d`.
  - In cycle N+1 the FIFO presents the data, and the arbiter captures `data_sel` into `data_out` with `push_out`=1 for cycle N+2.
  - When no pop occurred, `push_out`=0 and `data_out` holds its last value.
- In-flight words: up to 2 words can be in flight after `almost_full_out` rises. The destination `thr_full` must leave at least 2 slots of headroom. This is a system rule; the block does not check it.
- Reset values:
  - `state`=RESET, `idle_out`=0.
  - `pop_0`=`pop_1`=0.
  - `push_out`=0, `data_out`=8'h00.
  - `thr_full`=3'd0, `thr_empty`=3'd0.
  - `last_grant`=1, so lane 0 wins the first contention.
  - Pipeline valid bits are cleared.
- Reset mid-operation: in-flight words are dropped. `push_out` is 0 from the first cycle after the reset edge.
- Re-entry to INIT: pops stop immediately. Words already in the pipeline still complete their pushes over the next 2 cycles.

## Timing
- Pop to push latency: 2 cycles. A pop in cycle N gives `push_out`=1 in cycle N+2.
- Sustained throughput: 1 word per cycle, alternating 0,1,0,1 while both lanes stay non-empty.
- `pop_x` depends combinationally on `state`, `empty_x`, `almost_full_out`, `init`, `reset` and `last_grant`. No other output is combinational.
- `almost_full_out` rising in cycle N blocks the pop in cycle N. Pushes from pops in N-1 and N-2 still occur.
- `empty_x` is trusted in the same cycle. The arbiter never pops a lane whose empty flag is 1.

## Test plan
- Reset and init:
  - Stimulus: hold `reset` for 2 cycles, then release with `init`=1, `thr_full_in`=5, `thr_empty_in`=1 for 3 cycles, then `init`=0.
  - Required: `state` sequence 0→1→2; `thr_full`=5, `thr_empty`=1; `idle_out`=1 in IDLE; no pops or pushes throughout.
- Round robin:
  - Stimulus: preload lane 0 with A0,A1,A2 and lane 1 with B0,B1,B2.
  - Required: `data_out` sequence A0,B0,A1,B1,A2,B2 with `push_out` high for 6 consecutive cycles; then return to IDLE.
- Single lane:
  - Stimulus: only lane 1 holds 8'h3C,8'hC3.
  - Required: `pop_1` for 2 cycles and `pop_0` never; `data_out` 3C then C3 at +2 latency.
- Backpressure:
  - Stimulus: both lanes full; raise `almost_full_out` after 3 pops, hold it 4 cycles, then drop it.
  - Required: exactly 3 pushes before the stall; no pops while the flag is high; order resumes with the lane opposite the last grant.
- Reset mid-stream:
  - Stimulus: assert `reset` for 1 cycle in the cycle after a pop.
  - Required: `push_out`=0 from the next cycle; `data_out`=00; the first grant after recovery goes to lane 0.
- Init while active:
  - Stimulus: raise `init` during ACTIVE with `thr_full_in`=6.
  - Required: pops stop the same cycle; pending pushes (at most 2) complete; `thr_full`=6.
